// File: rtl/fetch_pc_btb_if.sv
// Fetch-stage bundle for fetch_pc_btb: hazard/EX-side controls in, fetch PC,
// prediction and performance counters out. master = pipeline side, slave = PC block.
interface fetch_pc_btb_if #(
  parameter int XLEN = 32
);
  logic            pc_en;
  logic            modify_pc_ex;
  logic [XLEN-1:0] update_pc_ex;
  logic            btb_upd_ex;
  logic [XLEN-1:0] btb_pc_ex;
  logic [XLEN-1:0] btb_tgt_ex;
  logic            btb_taken_ex;
  logic [XLEN-1:0] pc_if;
  logic            pred_taken_if;
  logic [XLEN-1:0] pred_tgt_if;
  logic [31:0]     stat_lookups;
  logic [31:0]     stat_hits;
  logic [31:0]     stat_redirects;

  modport master (
    output pc_en, modify_pc_ex, update_pc_ex,
    output btb_upd_ex, btb_pc_ex, btb_tgt_ex, btb_taken_ex,
    input  pc_if, pred_taken_if, pred_tgt_if,
    input  stat_lookups, stat_hits, stat_redirects
  );

  modport slave (
    input  pc_en, modify_pc_ex, update_pc_ex,
    input  btb_upd_ex, btb_pc_ex, btb_tgt_ex, btb_taken_ex,
    output pc_if, pred_taken_if, pred_tgt_if,
    output stat_lookups, stat_hits, stat_redirects
  );
endinterface

// File: rtl/fetch_pc_btb.sv
// IF-stage PC generator with a direct-mapped BTB (2-bit saturating counters).
// Optional performance counters are built when macro BTB_STATS_EN is defined;
// otherwise the stat outputs are tied to zero.
module fetch_pc_btb #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_pc_btb_if.slave bus
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [XLEN-1:0]  pc_reg;
  logic [XLEN-1:0]  pc_next;

  logic             valid_reg  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_reg    [BTB_ENTRIES];
  logic [XLEN-1:0]  target_reg [BTB_ENTRIES];
  logic [1:0]       ctr_reg    [BTB_ENTRIES];

  // Lookup side, indexed by the current fetch PC
  logic [IDX-1:0]   look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;

  assign look_idx = pc_reg[IDX+1:2];
  assign look_tag = pc_reg[XLEN-1:IDX+2];
  assign look_hit = valid_reg[look_idx] && (tag_reg[look_idx] == look_tag);

  assign bus.pc_if         = pc_reg;
  assign bus.pred_taken_if = look_hit & ctr_reg[look_idx][1];
  assign bus.pred_tgt_if   = look_hit ? target_reg[look_idx] : '0;

  // Training side, indexed by the resolving EX instruction
  logic [IDX-1:0]         upd_idx;
  logic [TAG_W-1:0]       upd_tag;
  logic                   upd_hit;
  logic [1:0]             upd_ctr;
  logic [1:0]             ctr_next;
  logic                   upd_write;
  logic [BTB_ENTRIES-1:0] entry_we;
  logic                   unused_bits;

  assign upd_idx     = bus.btb_pc_ex[IDX+1:2];
  assign upd_tag     = bus.btb_pc_ex[XLEN-1:IDX+2];
  assign upd_hit     = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign upd_ctr     = ctr_reg[upd_idx];
  // A miss that resolves not-taken leaves the table untouched
  assign upd_write   = bus.btb_upd_ex && (upd_hit || bus.btb_taken_ex);
  assign unused_bits = ^bus.btb_pc_ex[1:0];

  // Counter update: saturating step on a hit, weakly-taken on allocation
  always_comb begin
    ctr_next = 2'b10;
    if (upd_hit) begin
      if (bus.btb_taken_ex)
        ctr_next = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
      else
        ctr_next = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
    end
  end

  // Per-entry write enable decoded from the training index
  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_we
      assign entry_we[gi] = upd_write && (upd_idx == IDX'(gi));
    end
  endgenerate

  // BTB storage; writes land at the edge so same-cycle lookups see old contents
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= 2'b01;
      end
    end else begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        if (entry_we[i]) begin
          valid_reg[i] <= 1'b1;
          tag_reg[i]   <= upd_tag;
          ctr_reg[i]   <= ctr_next;
          if (bus.btb_taken_ex)
            target_reg[i] <= bus.btb_tgt_ex;
        end
      end
    end
  end

  // Next-PC select: redirect beats stall, stall beats prediction
  always_comb begin
    pc_next = pc_reg + XLEN'(4);
    if (bus.modify_pc_ex)
      pc_next = bus.update_pc_ex;
    else if (!bus.pc_en)
      pc_next = pc_reg;
    else if (bus.pred_taken_if)
      pc_next = bus.pred_tgt_if;
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (rst)
      pc_reg <= RESET_PC;
    else
      pc_reg <= pc_next;
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_reg;
  logic [31:0] hits_reg;
  logic [31:0] redirects_reg;

  // Performance counters; redirect cycles are not counted as lookups
  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_reg   <= '0;
      hits_reg      <= '0;
      redirects_reg <= '0;
    end else begin
      if (bus.modify_pc_ex)
        redirects_reg <= redirects_reg + 32'd1;
      if (bus.pc_en && !bus.modify_pc_ex) begin
        lookups_reg <= lookups_reg + 32'd1;
        if (bus.pred_taken_if)
          hits_reg <= hits_reg + 32'd1;
      end
    end
  end

  assign bus.stat_lookups   = lookups_reg;
  assign bus.stat_hits      = hits_reg;
  assign bus.stat_redirects = redirects_reg;
`else
  assign bus.stat_lookups   = 32'd0;
  assign bus.stat_hits      = 32'd0;
  assign bus.stat_redirects = 32'd0;
`endif
endmodule

// File: tb/tb_fetch_pc_btb.sv
// Directed bench for fetch_pc_btb: sequential PC, stall/redirect, BTB
// allocation, counter saturation, aliasing, wrap, reset and stat counters.
module tb_fetch_pc_btb;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef BTB_STATS_EN
  localparam logic [31:0] EXP_LOOKUPS   = 32'd8;
  localparam logic [31:0] EXP_HITS      = 32'd3;
  localparam logic [31:0] EXP_REDIRECTS = 32'd2;
`else
  localparam logic [31:0] EXP_LOOKUPS   = 32'd0;
  localparam logic [31:0] EXP_HITS      = 32'd0;
  localparam logic [31:0] EXP_REDIRECTS = 32'd0;
`endif

  fetch_pc_btb_if #(.XLEN(32)) bus ();

  fetch_pc_btb #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic train(input logic en, input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    bus.btb_upd_ex   = en;
    bus.btb_pc_ex    = pc;
    bus.btb_tgt_ex   = tgt;
    bus.btb_taken_ex = taken;
  endtask

  task automatic redirect(input logic en, input logic [31:0] addr);
    bus.modify_pc_ex = en;
    bus.update_pc_ex = addr;
  endtask

  initial begin
    rst = 1'b1;
    bus.pc_en = 1'b1;
    redirect(1'b0, 32'h0);
    train(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("rst_pc", bus.pc_if, 32'h0);
    chk("rst_pred", {31'b0, bus.pred_taken_if}, 32'h0);
    chk("rst_tgt", bus.pred_tgt_if, 32'h0);
    chk("rst_lookups", bus.stat_lookups, 32'h0);

    // Sequential fetch
    rst = 1'b0;
    chk("seq_pc0", bus.pc_if, 32'h0);
    tick(); chk("seq_pc4", bus.pc_if, 32'h4);
    tick(); chk("seq_pc8", bus.pc_if, 32'h8);
    tick(); chk("seq_pcC", bus.pc_if, 32'hC);
    chk("seq_pred", {31'b0, bus.pred_taken_if}, 32'h0);
    tick(); chk("seq_pc10", bus.pc_if, 32'h10);

    // Stall, then redirect during stall
    bus.pc_en = 1'b0;
    tick(); chk("stall_hold", bus.pc_if, 32'h10);
    redirect(1'b1, 32'h200);
    tick(); chk("redir_stall", bus.pc_if, 32'h200);
    redirect(1'b0, 32'h0);
    bus.pc_en = 1'b1;

    // Allocate 0x40 -> 0x80, then fetch 0x40
    train(1'b1, 32'h40, 32'h80, 1'b1);
    tick(); chk("alloc_pc", bus.pc_if, 32'h204);
    train(1'b0, 32'h0, 32'h0, 1'b0);
    redirect(1'b1, 32'h40);
    tick();
    redirect(1'b0, 32'h0);
    chk("hit_pred", {31'b0, bus.pred_taken_if}, 32'h1);
    chk("hit_tgt", bus.pred_tgt_if, 32'h80);
    tick(); chk("hit_next", bus.pc_if, 32'h80);
    chk("miss_0x80", {31'b0, bus.pred_taken_if}, 32'h0);

    // One not-taken: ctr 10 -> 01, still a hit but not predicted taken
    train(1'b1, 32'h40, 32'h123, 1'b0);
    tick();
    train(1'b0, 32'h0, 32'h0, 1'b0);
    redirect(1'b1, 32'h40);
    tick();
    redirect(1'b0, 32'h0);
    chk("nt_pred", {31'b0, bus.pred_taken_if}, 32'h0);
    chk("nt_tgt", bus.pred_tgt_if, 32'h80);
    tick(); chk("nt_next", bus.pc_if, 32'h44);

    // Hold at 0x40 and walk the counter: 01 ->10 ->11 ->11 ->10 ->01
    redirect(1'b1, 32'h40);
    bus.pc_en = 1'b0;
    tick();
    redirect(1'b0, 32'h0);
    chk("hold_pc40", bus.pc_if, 32'h40);
    train(1'b1, 32'h40, 32'h80, 1'b1);
    tick(); chk("ctr10_pred", {31'b0, bus.pred_taken_if}, 32'h1);
    tick(); chk("ctr11_pred", {31'b0, bus.pred_taken_if}, 32'h1);
    train(1'b1, 32'h40, 32'h90, 1'b1);
    tick(); chk("sat_pred", {31'b0, bus.pred_taken_if}, 32'h1);
    chk("retarget", bus.pred_tgt_if, 32'h90);
    train(1'b1, 32'h40, 32'h123, 1'b0);
    tick(); chk("dec10_pred", {31'b0, bus.pred_taken_if}, 32'h1);
    chk("nt_keep_tgt", bus.pred_tgt_if, 32'h90);
    tick(); chk("dec01_pred", {31'b0, bus.pred_taken_if}, 32'h0);

    // Aliasing at index 0: 0x440 evicts 0x40; 0x840 not-taken miss allocates nothing
    train(1'b1, 32'h440, 32'h500, 1'b1);
    tick();
    chk("alias_miss", {31'b0, bus.pred_taken_if}, 32'h0);
    chk("alias_tgt0", bus.pred_tgt_if, 32'h0);
    train(1'b1, 32'h840, 32'h900, 1'b0);
    redirect(1'b1, 32'h440);
    tick();
    redirect(1'b0, 32'h0);
    train(1'b0, 32'h0, 32'h0, 1'b0);
    chk("alias_hit", {31'b0, bus.pred_taken_if}, 32'h1);
    chk("alias_tgt", bus.pred_tgt_if, 32'h500);
    redirect(1'b1, 32'h840);
    tick();
    redirect(1'b0, 32'h0);
    chk("noalloc_pred", {31'b0, bus.pred_taken_if}, 32'h0);
    chk("noalloc_tgt", bus.pred_tgt_if, 32'h0);

    // Wrap from the top of the address space
    redirect(1'b1, 32'hFFFF_FFFC);
    tick();
    redirect(1'b0, 32'h0);
    bus.pc_en = 1'b1;
    chk("top_pc", bus.pc_if, 32'hFFFF_FFFC);
    tick(); chk("wrap_pc", bus.pc_if, 32'h0);

    // Reset overrides redirect and training in the same cycle
    rst = 1'b1;
    redirect(1'b1, 32'h440);
    train(1'b1, 32'h0, 32'h300, 1'b1);
    tick();
    chk("rst2_pc", bus.pc_if, 32'h0);
    chk("rst2_pred", {31'b0, bus.pred_taken_if}, 32'h0);
    chk("rst2_redirs", bus.stat_redirects, 32'h0);
    rst = 1'b0;
    train(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    redirect(1'b0, 32'h0);
    chk("rst2_cleared", {31'b0, bus.pred_taken_if}, 32'h0);

    // Stat scenario from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.pc_en = 1'b0;
    redirect(1'b1, 32'h40);
    train(1'b1, 32'h40, 32'h40, 1'b1);
    tick();
    redirect(1'b0, 32'h0);
    train(1'b0, 32'h0, 32'h0, 1'b0);
    bus.pc_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("loop_pc", bus.pc_if, 32'h40);
    redirect(1'b1, 32'h100);
    tick();
    redirect(1'b0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("run_pc", bus.pc_if, 32'h114);
    bus.pc_en = 1'b0;
    tick(); tick();
    chk("stat_lookups", bus.stat_lookups, EXP_LOOKUPS);
    chk("stat_hits", bus.stat_hits, EXP_HITS);
    chk("stat_redirects", bus.stat_redirects, EXP_REDIRECTS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
